// File: rtl/axil_cfg_sequencer_if.sv
// AXI4-Lite bundle between axil_cfg_sequencer (master) and the audio_to_axi register slave.
interface axil_cfg_sequencer_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic [ADDR_W-1:0]   AWADDR;
   logic [2:0]          AWPROT;
   logic                AWVALID;
   logic                AWREADY;
   logic [DATA_W-1:0]   WDATA;
   logic [DATA_W/8-1:0] WSTRB;
   logic                WVALID;
   logic                WREADY;
   logic [1:0]          BRESP;
   logic                BVALID;
   logic                BREADY;
   logic [ADDR_W-1:0]   ARADDR;
   logic [2:0]          ARPROT;
   logic                ARVALID;
   logic                ARREADY;
   logic [DATA_W-1:0]   RDATA;
   logic [1:0]          RRESP;
   logic                RVALID;
   logic                RREADY;

   modport master (
      output AWADDR, AWPROT, AWVALID, WDATA, WSTRB, WVALID, BREADY,
      output ARADDR, ARPROT, ARVALID, RREADY,
      input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
   );

   modport slave (
      input  AWADDR, AWPROT, AWVALID, WDATA, WSTRB, WVALID, BREADY,
      input  ARADDR, ARPROT, ARVALID, RREADY,
      output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
   );
endinterface

// File: rtl/axil_cfg_sequencer.sv
// Writes NUM_REGS configuration words over AXI4-Lite, one transaction at a time.
// Define READBACK_VERIFY_EN to read each register back and compare it after the write.
module axil_cfg_sequencer #(
   parameter int                            C_M_AXI_ADDR_WIDTH = 32,
   parameter int                            C_M_AXI_DATA_WIDTH = 32,
   parameter logic [C_M_AXI_ADDR_WIDTH-1:0] C_BASE_ADDR        = '0,
   parameter int                            NUM_REGS           = 4
) (
   input  logic                 ACLK,
   input  logic                 ARESETN,
   input  logic                 start,
   input  logic [127:0]         cfg_data,
   output logic                 busy,
   output logic                 done,
   output logic                 error,
   output logic [1:0]           err_index,
   axil_cfg_sequencer_if.master m_axi
);
   localparam int         AW       = C_M_AXI_ADDR_WIDTH;
   localparam logic [1:0] LAST_IDX = 2'(NUM_REGS - 1);

   typedef enum logic [2:0] {
      IDLE,
      WR_REQ,
      WR_RESP,
`ifdef READBACK_VERIFY_EN
      RD_REQ,
      RD_RESP,
`endif
      NEXT,
      FINISH
   } state_e;

   state_e                        state_q, state_d;
   logic [1:0]                    idx_q, idx_d;
   logic [127:0]                  cfg_q, cfg_d;
   logic                          aw_done_q, aw_done_d;
   logic                          w_done_q, w_done_d;
   logic                          error_q, error_d;
   logic [1:0]                    err_idx_q, err_idx_d;
   logic [C_M_AXI_DATA_WIDTH-1:0] cur_word;
   logic [AW-1:0]                 cur_addr;
   logic                          aw_hs, w_hs;

   assign cur_word = cfg_q[{idx_q, 5'd0} +: 32];
   assign cur_addr = C_BASE_ADDR + AW'({idx_q, 2'b00});
   assign aw_hs    = m_axi.AWVALID & m_axi.AWREADY;
   assign w_hs     = m_axi.WVALID & m_axi.WREADY;

`ifndef READBACK_VERIFY_EN
   logic unused_rd;
   assign unused_rd = ^{m_axi.ARREADY, m_axi.RDATA, m_axi.RRESP, m_axi.RVALID};
`endif

   // NOTE: the latched word store is reset as well; it is small and keeps WDATA at 0 after reset.
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         state_q   <= IDLE;
         idx_q     <= '0;
         cfg_q     <= '0;
         aw_done_q <= 1'b0;
         w_done_q  <= 1'b0;
         error_q   <= 1'b0;
         err_idx_q <= '0;
      end else begin
         // NOTE: non-blocking only, so every register samples pre-edge values.
         state_q   <= state_d;
         idx_q     <= idx_d;
         cfg_q     <= cfg_d;
         aw_done_q <= aw_done_d;
         w_done_q  <= w_done_d;
         error_q   <= error_d;
         err_idx_q <= err_idx_d;
      end
   end

   always_comb begin
      // NOTE: every _d defaults to its register first, so no path can infer a latch.
      state_d   = state_q;
      idx_d     = idx_q;
      cfg_d     = cfg_q;
      aw_done_d = aw_done_q;
      w_done_d  = w_done_q;
      error_d   = error_q;
      err_idx_d = err_idx_q;
      case (state_q)
         IDLE: if (start) begin
            cfg_d     = cfg_data;
            idx_d     = '0;
            error_d   = 1'b0;
            err_idx_d = '0;
            state_d   = WR_REQ;
         end
         WR_REQ: begin
            if (aw_hs) aw_done_d = 1'b1;
            if (w_hs)  w_done_d  = 1'b1;
            if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
               aw_done_d = 1'b0;
               w_done_d  = 1'b0;
               state_d   = WR_RESP;
            end
         end
         WR_RESP: if (m_axi.BVALID) begin
            if (m_axi.BRESP != 2'b00) begin
               error_d   = 1'b1;
               err_idx_d = idx_q;
               state_d   = FINISH;
            end else begin
`ifdef READBACK_VERIFY_EN
               state_d = RD_REQ;
`else
               state_d = NEXT;
`endif
            end
         end
`ifdef READBACK_VERIFY_EN
         RD_REQ: if (m_axi.ARREADY) state_d = RD_RESP;
         RD_RESP: if (m_axi.RVALID) begin
            if (m_axi.RRESP != 2'b00 || m_axi.RDATA != cur_word) begin
               error_d   = 1'b1;
               err_idx_d = idx_q;
               state_d   = FINISH;
            end else begin
               state_d = NEXT;
            end
         end
`endif
         NEXT: begin
            if (idx_q == LAST_IDX) begin
               state_d = FINISH;
            end else begin
               idx_d   = idx_q + 2'd1;
               state_d = WR_REQ;
            end
         end
         FINISH:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      busy          = (state_q != IDLE) && (state_q != FINISH);
      done          = (state_q == FINISH);
      error         = error_q;
      err_index     = err_idx_q;
      m_axi.AWADDR  = '0;
      m_axi.AWPROT  = 3'b000;
      m_axi.AWVALID = 1'b0;
      m_axi.WDATA   = '0;
      m_axi.WSTRB   = '0;
      m_axi.WVALID  = 1'b0;
      m_axi.BREADY  = 1'b0;
      m_axi.ARADDR  = '0;
      m_axi.ARPROT  = 3'b000;
      m_axi.ARVALID = 1'b0;
      m_axi.RREADY  = 1'b0;
      case (state_q)
         WR_REQ: begin
            m_axi.AWADDR  = cur_addr;
            m_axi.AWVALID = !aw_done_q;
            m_axi.WDATA   = cur_word;
            m_axi.WSTRB   = '1;
            m_axi.WVALID  = !w_done_q;
         end
         WR_RESP: m_axi.BREADY = 1'b1;
`ifdef READBACK_VERIFY_EN
         RD_REQ: begin
            m_axi.ARADDR  = cur_addr;
            m_axi.ARVALID = 1'b1;
         end
         RD_RESP: m_axi.RREADY = 1'b1;
`endif
         default: ;
      endcase
   end
endmodule

// File: tb/tb_axil_cfg_sequencer.sv
// Self-checking bench for axil_cfg_sequencer: table vectors, reset abort, and random runs vs. a transaction-level model.
module tb_axil_cfg_sequencer;
`ifdef READBACK_VERIFY_EN
   localparam bit VER = 1'b1;
   localparam int N   = 4;
`else
   localparam bit VER = 1'b0;
   localparam int N   = 2;
`endif
   localparam logic [31:0]  BASE  = 32'h4000_1000;
   localparam logic [127:0] CFG_A = {32'hbeef0011, 32'hdead0011, 32'habcd0001, 32'h0101ffff};

   typedef struct {
      bit          wr;
      logic [31:0] addr;
      logic [31:0] data;
   } acc_t;

   typedef struct {
      string        name;
      logic [127:0] cfg;
      int           awd, wd, ard, bad_b, bad_r;
      bit           mid;
      bit           exp_err;
      logic [1:0]   exp_idx;
      int           exp_lat;
   } vec_t;

   logic         ACLK     = 1'b0;
   logic         ARESETN  = 1'b1;
   logic         start    = 1'b0;
   logic [127:0] cfg_data = '0;
   logic         busy, done, error;
   logic [1:0]   err_index;

   int applied = 0, miscompares = 0;
   int awd = 0, wd = 0, ard = 0, bad_b = -1, bad_r = -1;

   axil_cfg_sequencer_if #(.ADDR_W(32), .DATA_W(32)) axi ();

   axil_cfg_sequencer #(
      .C_M_AXI_ADDR_WIDTH(32),
      .C_M_AXI_DATA_WIDTH(32),
      .C_BASE_ADDR       (BASE),
      .NUM_REGS          (N)
   ) dut (
      .ACLK     (ACLK),
      .ARESETN  (ARESETN),
      .start    (start),
      .cfg_data (cfg_data),
      .busy     (busy),
      .done     (done),
      .error    (error),
      .err_index(err_index),
      .m_axi    (axi)
   );

   always #5 ACLK = ~ACLK;

   // Slave with programmable ready delays and fault injection.
   int          aw_cnt, w_cnt, ar_cnt;
   logic        aw_got, w_got, bvalid_q, rvalid_q;
   logic [31:0] aw_addr_l, wdata_l, rdata_q;
   logic [1:0]  bresp_q;
   logic [31:0] mem [4];
   acc_t        log_q[$];

   wire        aw_hs   = axi.AWVALID & axi.AWREADY;
   wire        w_hs    = axi.WVALID & axi.WREADY;
   wire        ar_hs   = axi.ARVALID & axi.ARREADY;
   wire [31:0] wr_addr = aw_hs ? axi.AWADDR : aw_addr_l;
   wire [31:0] wr_data = w_hs ? axi.WDATA : wdata_l;
   wire        wr_done = (aw_got | aw_hs) & (w_got | w_hs);

   function automatic int reg_of(input logic [31:0] a);
      return int'((a - BASE) >> 2);
   endfunction

   assign axi.AWREADY = axi.AWVALID && (aw_cnt == awd);
   assign axi.WREADY  = axi.WVALID && (w_cnt == wd);
   assign axi.ARREADY = axi.ARVALID && (ar_cnt == ard);
   assign axi.BVALID  = bvalid_q;
   assign axi.BRESP   = bresp_q;
   assign axi.RVALID  = rvalid_q;
   assign axi.RDATA   = rdata_q;
   assign axi.RRESP   = 2'b00;

   always @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0;
         aw_got <= 1'b0; w_got <= 1'b0; bvalid_q <= 1'b0; rvalid_q <= 1'b0;
         aw_addr_l <= '0; wdata_l <= '0; rdata_q <= '0; bresp_q <= 2'b00;
      end else begin
         if (aw_hs) begin aw_got <= 1'b1; aw_addr_l <= axi.AWADDR; aw_cnt <= 0; end
         else if (axi.AWVALID) aw_cnt <= aw_cnt + 1;
         if (w_hs) begin w_got <= 1'b1; wdata_l <= axi.WDATA; w_cnt <= 0; end
         else if (axi.WVALID) w_cnt <= w_cnt + 1;
         if (wr_done) begin
            log_q.push_back('{1'b1, wr_addr, wr_data});
            mem[reg_of(wr_addr)] <= wr_data;
            bvalid_q <= 1'b1;
            bresp_q  <= (reg_of(wr_addr) == bad_b) ? 2'b10 : 2'b00;
            aw_got   <= 1'b0;
            w_got    <= 1'b0;
         end else if (axi.BVALID && axi.BREADY) begin
            bvalid_q <= 1'b0;
         end
         if (ar_hs) begin
            log_q.push_back('{1'b0, axi.ARADDR, 32'h0});
            rvalid_q <= 1'b1;
            rdata_q  <= (reg_of(axi.ARADDR) == bad_r) ? 32'h0 : mem[reg_of(axi.ARADDR)];
            ar_cnt   <= 0;
         end else begin
            if (axi.ARVALID) ar_cnt <= ar_cnt + 1;
            if (axi.RVALID && axi.RREADY) rvalid_q <= 1'b0;
         end
      end
   end

   // Protocol monitor: payload stability, single outstanding transaction, constant fields.
   int          done_cnt = 0, aw_cyc = 0, w_cyc = 0, viol = 0;
   logic        aw_pend = 1'b0, w_pend = 1'b0, ar_pend = 1'b0;
   logic [31:0] aw_pa = '0, w_pd = '0, ar_pa = '0;

   always @(posedge ACLK) begin
      if (ARESETN) begin
         done_cnt <= done_cnt + int'(done);
         aw_cyc   <= aw_cyc + int'(axi.AWVALID);
         w_cyc    <= w_cyc + int'(axi.WVALID);
         viol     <= viol
                   + int'(aw_pend && (!axi.AWVALID || axi.AWADDR != aw_pa))
                   + int'(w_pend && (!axi.WVALID || axi.WDATA != w_pd))
                   + int'(ar_pend && (!axi.ARVALID || axi.ARADDR != ar_pa))
                   + int'((axi.AWVALID || axi.WVALID || axi.ARVALID) && (bvalid_q || rvalid_q))
                   + int'(axi.ARVALID && (axi.AWVALID || axi.WVALID))
                   + int'(w_hs && axi.WSTRB != 4'hf)
                   + int'((axi.AWVALID && axi.AWPROT != 3'b000) || (axi.ARVALID && axi.ARPROT != 3'b000));
      end
      aw_pend <= ARESETN && axi.AWVALID && !axi.AWREADY;
      w_pend  <= ARESETN && axi.WVALID && !axi.WREADY;
      ar_pend <= ARESETN && axi.ARVALID && !axi.ARREADY;
      aw_pa   <= axi.AWADDR;
      w_pd    <= axi.WDATA;
      ar_pa   <= axi.ARADDR;
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      applied++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   // Reference model: the list of accesses a sequence makes, its outcome and cycle cost.
   acc_t       exp_q[$];
   bit         m_err;
   logic [1:0] m_idx;
   int         m_lat, m_nw;

   task automatic build_model(input logic [127:0] cfg, input int a, input int w, input int r,
                              input int bb, input int br);
      logic [31:0] word;
      exp_q.delete();
      m_err = 1'b0; m_idx = 2'd0; m_lat = 0; m_nw = 0;
      for (int i = 0; i < N; i++) begin
         word = cfg[32*i +: 32];
         exp_q.push_back('{1'b1, BASE + 32'(4*i), word});
         m_nw++;
         m_lat += 2 + ((a > w) ? a : w);
         if (i == bb) begin m_err = 1'b1; m_idx = 2'(i); break; end
         if (VER) begin
            exp_q.push_back('{1'b0, BASE + 32'(4*i), 32'h0});
            m_lat += 2 + r;
            if (i == br && word != 32'h0) begin m_err = 1'b1; m_idx = 2'(i); break; end
         end
         m_lat += 1;
      end
   endtask

   task automatic run_seq(input string tag, input logic [127:0] cfg, input int a, input int w,
                          input int r, input int bb, input int br, input bit mid,
                          input bit exp_err, input logic [1:0] exp_idx, input int exp_lat);
      int cyc, d0, aw0, w0, v0, n;
      build_model(cfg, a, w, r, bb, br);
      @(negedge ACLK);
      awd = a; wd = w; ard = r; bad_b = bb; bad_r = br;
      log_q.delete();
      d0 = done_cnt; aw0 = aw_cyc; w0 = w_cyc; v0 = viol;
      start = 1'b1; cfg_data = cfg;
      @(negedge ACLK);
      start = 1'b0; cfg_data = ~cfg;
      check({tag, ".busy_on"}, 64'(busy), 64'd1);
      check({tag, ".err_clr"}, 64'(error), 64'd0);
      cyc = 0;
      while (!done && cyc < 400) begin
         start = mid && (cyc == 2);
         @(negedge ACLK);
         cyc++;
      end
      start = 1'b0;
      check({tag, ".done_latency"}, 64'(cyc), 64'(exp_lat));
      check({tag, ".busy_at_done"}, 64'(busy), 64'd0);
      check({tag, ".error"}, 64'(error), 64'(exp_err));
      check({tag, ".err_index"}, 64'(err_index), 64'(exp_idx));
      @(negedge ACLK);
      check({tag, ".done_pulses"}, 64'(done_cnt - d0), 64'd1);
      check({tag, ".done_low"}, 64'(done), 64'd0);
      check({tag, ".error_hold"}, 64'(error), 64'(exp_err));
      n = log_q.size();
      check({tag, ".access_count"}, 64'(n), 64'(exp_q.size()));
      for (int i = 0; i < n && i < exp_q.size(); i++) begin
         check($sformatf("%s.acc%0d_addr", tag, i), {31'b0, log_q[i].wr, log_q[i].addr},
               {31'b0, exp_q[i].wr, exp_q[i].addr});
         check($sformatf("%s.acc%0d_data", tag, i), 64'(log_q[i].data), 64'(exp_q[i].data));
      end
      check({tag, ".awvalid_cycles"}, 64'(aw_cyc - aw0), 64'(m_nw * (a + 1)));
      check({tag, ".wvalid_cycles"}, 64'(w_cyc - w0), 64'(m_nw * (w + 1)));
      check({tag, ".protocol"}, 64'(viol - v0), 64'd0);
   endtask

   initial begin
      vec_t tbl[6];
      int   k, d0;
      tbl[0] = '{"basic",   CFG_A, 0, 0, 0, -1, -1, 1'b0, 1'b0, 2'd0, VER ? 20 : 6};
      tbl[1] = '{"aw_slow", CFG_A, 3, 0, 0, -1, -1, 1'b0, 1'b0, 2'd0, VER ? 32 : 12};
      tbl[2] = '{"bresp",   CFG_A, 0, 0, 0, VER ? 2 : 1, -1, 1'b0, 1'b1,
                 VER ? 2'd2 : 2'd1, VER ? 12 : 5};
      tbl[3] = '{"rdata",   CFG_A, 0, 0, 0, -1, 1, 1'b0, VER, VER ? 2'd1 : 2'd0, VER ? 9 : 6};
      tbl[4] = '{"w_slow",  ~CFG_A, 0, 2, 1, -1, -1, 1'b1, 1'b0, 2'd0, VER ? 32 : 10};
      tbl[5] = '{"bresp0",  CFG_A, 0, 0, 0, 0, -1, 1'b1, 1'b1, 2'd0, 2};

      #1 ARESETN = 1'b0;
      #1;
      check("reset.ctrl", 64'({busy, done, error, axi.AWVALID, axi.WVALID, axi.ARVALID,
                               axi.BREADY, axi.RREADY, err_index}), 64'd0);
      check("reset.addr", {axi.AWADDR, axi.ARADDR}, 64'd0);
      check("reset.wdata", 64'(axi.WDATA), 64'd0);
      repeat (3) @(negedge ACLK);
      ARESETN = 1'b1;

      foreach (tbl[i])
         run_seq(tbl[i].name, tbl[i].cfg, tbl[i].awd, tbl[i].wd, tbl[i].ard, tbl[i].bad_b,
                 tbl[i].bad_r, tbl[i].mid, tbl[i].exp_err, tbl[i].exp_idx, tbl[i].exp_lat);

      // Reset in WR_RESP: everything drops, no done, next start begins at index 0.
      @(negedge ACLK);
      awd = 0; wd = 0; ard = 0; bad_b = -1; bad_r = -1;
      start = 1'b1; cfg_data = CFG_A;
      @(negedge ACLK);
      start = 1'b0;
      k = 0;
      while (!axi.BREADY && k < 20) begin @(negedge ACLK); k++; end
      check("abort.in_wr_resp", 64'(axi.BREADY), 64'd1);
      d0 = done_cnt;
      ARESETN = 1'b0;
      #1;
      check("abort.ctrl", 64'({busy, done, error, axi.AWVALID, axi.WVALID, axi.ARVALID,
                               axi.BREADY, axi.RREADY, err_index}), 64'd0);
      check("abort.addr", {axi.AWADDR, axi.ARADDR}, 64'd0);
      repeat (2) @(negedge ACLK);
      check("abort.busy_held", 64'(busy), 64'd0);
      ARESETN = 1'b1;
      repeat (3) @(negedge ACLK);
      check("abort.no_done", 64'(done_cnt - d0), 64'd0);
      check("abort.idle", 64'(busy), 64'd0);
      run_seq("post_abort", CFG_A ^ 128'h5a5a_0000_1111_2222_3333_4444_5555_6666,
              0, 0, 0, -1, -1, 1'b0, 1'b0, 2'd0, VER ? 20 : 6);

      for (int t = 0; t < 20; t++) begin
         logic [127:0] c;
         int a, w, r, bb, br;
         bit mid;
         c   = {$urandom, $urandom, $urandom, $urandom};
         a   = int'($urandom_range(0, 3));
         w   = int'($urandom_range(0, 3));
         r   = int'($urandom_range(0, 3));
         bb  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, N - 1)) : -1;
         br  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, N - 1)) : -1;
         mid = 1'($urandom_range(0, 1));
         build_model(c, a, w, r, bb, br);
         run_seq($sformatf("rnd%0d", t), c, a, w, r, bb, br, mid, m_err, m_idx, m_lat);
      end

      $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
      $finish;
   end
endmodule

// File: doc/axil_cfg_sequencer.md
AXIL_CFG_SEQUENCER -- requirements
Module: axil_cfg_sequencer

Interface
REQ-001 Parameter C_M_AXI_ADDR_WIDTH, default 32, AXI4-Lite address width.
REQ-002 Parameter C_M_AXI_DATA_WIDTH, default 32, AXI4-Lite data width; only 32 is supported.
REQ-003 Parameter C_BASE_ADDR, default 32'h0000_0000, address of register 0 of the audio_to_axi slave.
REQ-004 Parameter NUM_REGS, default 4, registers programmed per sequence; legal range 1..4.
REQ-005 Port ACLK  input  1  the single clock; all logic is on its rising edge.
REQ-006 Port ARESETN  input  1  reset; asynchronous, active-low.
REQ-007 Port start  input  1  one-cycle request to begin a sequence.
REQ-008 Port cfg_data  input  128  register values; register i takes bits [32i+31:32i].
REQ-009 Port busy, done, error  output  1 each  sequence active; one-cycle completion pulse; sticky failure flag.
REQ-010 Port err_index  output  2  index of the register that failed.
REQ-011 Ports M_AXI_AWADDR/AWPROT/AWVALID, WDATA/WSTRB/WVALID, BREADY  output; M_AXI_AWREADY, WREADY, BRESP/BVALID  input  standard AXI4-Lite widths.
REQ-012 Ports M_AXI_ARADDR/ARPROT/ARVALID, RREADY  output; M_AXI_ARREADY, RDATA/RRESP/RVALID  input  standard AXI4-Lite widths.

Function
REQ-013 The state machine SHALL have the states IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, NEXT and FINISH.
REQ-014 IDLE: on start=1, cfg_data SHALL be latched, the index SHALL clear to 0, error SHALL clear, busy SHALL go to 1, and the next state SHALL be WR_REQ.
REQ-015 start SHALL be ignored in every state other than IDLE.
REQ-016 WR_REQ: AWVALID and WVALID SHALL both assert in the same cycle, with AWADDR = C_BASE_ADDR + 4*index, WDATA = latched word[index], WSTRB = 4'hF and AWPROT = ARPROT = 3'b000.
REQ-017 In WR_REQ, each of AWVALID and WVALID SHALL deassert independently the cycle after its own VALID&READY; once both have been accepted, including simultaneous acceptance, the state SHALL become WR_RESP.
REQ-018 Once a VALID is asserted, it and its payload SHALL hold stable until accepted.
REQ-019 WR_RESP: BREADY SHALL be 1; on BVALID, BRESP != 2'b00 SHALL set error and go to FINISH, otherwise the state SHALL go to RD_REQ when READBACK_VERIFY_EN is defined, or to NEXT when it is not.
REQ-020 RD_REQ: ARVALID SHALL assert with ARADDR = C_BASE_ADDR + 4*index and hold until ARREADY; the state SHALL then become RD_RESP.
REQ-021 RD_RESP: RREADY SHALL be 1; on RVALID, RRESP != 2'b00 or RDATA != latched word[index] SHALL set error, otherwise the state SHALL become NEXT.
REQ-022 NEXT: if index == NUM_REGS-1 the state SHALL go to FINISH; otherwise the index SHALL increment and the state SHALL go to WR_REQ. NEXT SHALL take exactly one cycle.
REQ-023 On error, err_index SHALL take the current index and the state SHALL go to FINISH; no later registers SHALL be accessed.
REQ-024 FINISH: done SHALL pulse for exactly one cycle, busy SHALL drop in that same cycle, and the state SHALL return to IDLE.
REQ-025 error and err_index SHALL hold until the next accepted start.
REQ-026 At most one AXI transaction SHALL be outstanding at a time.
REQ-027 The minimum per-register latency with zero-wait slaves SHALL be 5 cycles with verify (WR_REQ, WR_RESP, RD_REQ, RD_RESP, NEXT) and 3 cycles without.

Reset
REQ-028 While ARESETN=0, the state SHALL be IDLE; all VALID and READY outputs, busy, done and error SHALL be 0; err_index, index, addresses and data SHALL be 0.
REQ-029 An assertion of ARESETN mid-transaction SHALL abort the transaction immediately with no completion pulse; after release the block SHALL wait for a new start.

Configuration
REQ-030 Macro READBACK_VERIFY_EN defined: the RD_REQ and RD_RESP states and the compare logic SHALL be present as described in REQ-019 to REQ-021.
REQ-031 Macro READBACK_VERIFY_EN undefined: the read states SHALL be absent, ARVALID and RREADY SHALL be tied to 0, ARADDR SHALL be tied to 0, and error SHALL reflect only BRESP.

Verification
REQ-032 Zero-wait slave, verify on, cfg_data = {beef0011, dead0011, abcd0001, 0101FFFF}, start -> four writes then readbacks at offsets 0x0, 0x4, 0x8, 0xC; done pulses 20 cycles after start; error=0.
REQ-033 Slave delays AWREADY by 3 cycles and WREADY by 0 -> WVALID drops after 1 cycle, AWVALID holds 4 cycles, AWADDR stable throughout, exactly one write per register.
REQ-034 Slave returns BRESP=2'b10 on register 2 -> error=1, err_index=2, no access to offset 0xC, done pulses once.
REQ-035 Slave returns RDATA=32'h0 for register 1 -> error=1, err_index=1, sequence stops after that read.
REQ-036 Assert ARESETN=0 while in WR_RESP, then release and start again -> all outputs 0 during reset, no done pulse, the new sequence restarts at index 0.
REQ-037 Macro undefined, NUM_REGS=2 -> two writes only, ARVALID never 1, done pulses 6 cycles after start.
